// File: rtl/sum_accumulator.sv
// Batches {carryout,sum} samples from the 4-bit adder into a wider total.
// Holds each finished total with a sticky overflow flag until it is taken.
module sum_accumulator #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8,
  parameter int COUNT = 4,
  localparam int CW   = $clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  sum,
  input  logic             carryout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [CW-1:0]    cnt
);

  typedef enum logic {ACC, DONE} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [ACC_W:0]   add;

  // Extra top bit of the add is the wrap indicator for the sticky flag.
  assign add = {1'b0, acc_out}
             + {{(ACC_W - IN_W){1'b0}}, carryout, sum};

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_out;
    ovf_nxt   = overflow;
    cnt_nxt   = cnt;
    if (clr) begin
      state_nxt = ACC;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        ACC: begin
          if (in_valid) begin
            acc_nxt = add[ACC_W-1:0];
            ovf_nxt = overflow | add[ACC_W];
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(COUNT - 1))
              state_nxt = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nxt = ACC;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
          end
        end
        default: state_nxt = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACC;
      acc_out  <= '0;
      overflow <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      acc_out  <= acc_nxt;
      overflow <= ovf_nxt;
      cnt      <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed vector table, overflow batch on a COUNT=16 instance, and a
// randomized handshake run against a bench-side batch model.
module tb_sum_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] sum = '0;
  logic       carryout = 1'b0;
  logic       in_ready, out_valid, overflow;
  logic [7:0] acc_out;
  logic [2:0] cnt;

  logic       b_clr = 1'b0;
  logic       b_in_valid = 1'b0;
  logic       b_out_ready = 1'b0;
  logic [3:0] b_sum = '0;
  logic       b_carryout = 1'b0;
  logic       b_in_ready, b_out_valid, b_overflow;
  logic [7:0] b_acc_out;
  logic [4:0] b_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sum_accumulator #(.IN_W(4), .ACC_W(8), .COUNT(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .carryout(carryout),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .overflow(overflow), .cnt(cnt)
  );

  sum_accumulator #(.IN_W(4), .ACC_W(8), .COUNT(16)) dut16 (
    .clk(clk), .rst(rst), .clr(b_clr),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sum(b_sum), .carryout(b_carryout),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .acc_out(b_acc_out), .overflow(b_overflow), .cnt(b_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       v;
    logic [4:0] smp;
    logic       ordy;
    logic       clr;
    logic       e_ir;
    logic       e_ov;
    logic [7:0] e_acc;
    logic       e_ovf;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic v, input int smp,
                              input logic ordy, input logic c,
                              input logic ir, input logic ov,
                              input int acc, input logic ovf,
                              input int n);
    vec_t r;
    r.v = v; r.smp = 5'(smp); r.ordy = ordy; r.clr = c;
    r.e_ir = ir; r.e_ov = ov; r.e_acc = 8'(acc);
    r.e_ovf = ovf; r.e_cnt = 3'(n);
    return r;
  endfunction

  initial begin
    int n_acc, m_sum, batches, cyc;
    bit done;
    logic v, o;
    logic [4:0] s;

    // Batch 6,15,18,25 then backpressure, take, gaps, clr, 3+3+3+3.
    tbl[0]  = mk(1, 6,  0, 0, 1, 0, 6,  0, 1);
    tbl[1]  = mk(1, 15, 0, 0, 1, 0, 21, 0, 2);
    tbl[2]  = mk(1, 18, 0, 0, 1, 0, 39, 0, 3);
    tbl[3]  = mk(1, 25, 0, 0, 0, 1, 64, 0, 4);
    tbl[4]  = mk(1, 31, 0, 0, 0, 1, 64, 0, 4);
    tbl[5]  = mk(1, 31, 0, 0, 0, 1, 64, 0, 4);
    tbl[6]  = mk(1, 31, 0, 0, 0, 1, 64, 0, 4);
    tbl[7]  = mk(1, 31, 0, 0, 0, 1, 64, 0, 4);
    tbl[8]  = mk(1, 31, 0, 0, 0, 1, 64, 0, 4);
    tbl[9]  = mk(1, 31, 1, 0, 1, 0, 0,  0, 0);
    tbl[10] = mk(1, 3,  0, 0, 1, 0, 3,  0, 1);
    tbl[11] = mk(0, 3,  0, 0, 1, 0, 3,  0, 1);
    tbl[12] = mk(1, 3,  0, 0, 1, 0, 6,  0, 2);
    tbl[13] = mk(0, 3,  0, 0, 1, 0, 6,  0, 2);
    tbl[14] = mk(1, 5,  0, 1, 1, 0, 0,  0, 0);
    tbl[15] = mk(1, 3,  0, 0, 1, 0, 3,  0, 1);
    tbl[16] = mk(1, 3,  0, 0, 1, 0, 6,  0, 2);
    tbl[17] = mk(1, 3,  0, 0, 1, 0, 9,  0, 3);
    tbl[18] = mk(1, 3,  0, 0, 0, 1, 12, 0, 4);
    tbl[19] = mk(0, 3,  0, 0, 0, 1, 12, 0, 4);
    tbl[20] = mk(1, 7,  0, 1, 1, 0, 0,  0, 0);
    tbl[21] = mk(0, 0,  1, 0, 1, 0, 0,  0, 0);

    rst = 1'b1;
    #12;
    rst = 1'b0;
    step();
    chk("rst_ir", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_cnt", cnt, 0);

    // Mid-batch asynchronous reset, observed before the next edge.
    in_valid = 1'b1; {carryout, sum} = 5'd9;
    step();
    step();
    chk("pre_rst_acc", acc_out, 18);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_acc", acc_out, 0);
    chk("async_cnt", cnt, 0);
    chk("async_ir", in_ready, 1);
    chk("async_ov", out_valid, 0);
    #1 rst = 1'b0;
    step();

    foreach (tbl[i]) begin
      in_valid = tbl[i].v;
      {carryout, sum} = tbl[i].smp;
      out_ready = tbl[i].ordy;
      clr = tbl[i].clr;
      step();
      chk($sformatf("v%0d_ir", i), in_ready, tbl[i].e_ir);
      chk($sformatf("v%0d_ov", i), out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_acc", i), acc_out, tbl[i].e_acc);
      chk($sformatf("v%0d_ovf", i), overflow, tbl[i].e_ovf);
      chk($sformatf("v%0d_cnt", i), cnt, tbl[i].e_cnt);
    end
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b0;

    // COUNT=16: 16 x 31 = 496 wraps to 240 with sticky overflow.
    b_in_valid = 1'b1; {b_carryout, b_sum} = 5'd31;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 8) begin
        chk("b_wrap_acc", b_acc_out, 23);
        chk("b_wrap_ovf", b_overflow, 1);
      end
    end
    chk("b_ov", b_out_valid, 1);
    chk("b_acc", b_acc_out, 240);
    chk("b_ovf", b_overflow, 1);
    chk("b_cnt", b_cnt, 16);
    b_out_ready = 1'b1;
    step();
    chk("b_take_acc", b_acc_out, 0);
    chk("b_take_ovf", b_overflow, 0);
    b_out_ready = 1'b0; {b_carryout, b_sum} = 5'd1;
    step();
    chk("b_next_acc", b_acc_out, 1);
    chk("b_next_ovf", b_overflow, 0);
    b_in_valid = 1'b0;

    // Random handshakes on the COUNT=4 instance against a batch model.
    n_acc = 0; m_sum = 0; batches = 0; cyc = 0; done = 0;
    while (batches < 1000 && cyc < 30000) begin
      v = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      s = 5'($urandom_range(0, 31));
      in_valid = v; out_ready = o; {carryout, sum} = s;
      chk("rnd_ov", out_valid, int'(done));
      if (done) begin
        chk("rnd_total", acc_out, m_sum % 256);
        chk("rnd_cnt", cnt, 4);
      end
      step();
      cyc++;
      if (!done && v) begin
        m_sum += int'(s);
        n_acc++;
        if (n_acc == 4) done = 1;
      end else if (done && o) begin
        done = 0; n_acc = 0; m_sum = 0;
        batches++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_batches", batches, 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
